// File: rtl/ps2_cmd_interpreter.sv
// Decodes "SET <letter> <digits>" and "FIRE" command lines into channel registers, one digit per clock.
// Optional SIGNED_VAL_EN: accepts a leading '-' and commits two's-complement values with signed limits.
module ps2_cmd_interpreter #(
   parameter int                      LINE_CHARS = 32,
   parameter int                      NUM_CH     = 2,
   parameter int                      VAL_W      = 32,
   parameter int                      MAX_DIGITS = 5,
   parameter logic [8*NUM_CH-1:0]     CH_LETTERS = 16'h5641,
   parameter logic [VAL_W*NUM_CH-1:0] RESET_VALS = {32'd60, 32'd70}
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [8*LINE_CHARS-1:0]   input_line,
   input  logic                      line_ready,
   output logic [VAL_W*NUM_CH-1:0]   values,
   output logic [NUM_CH-1:0]         update,
   output logic                      fire,
   output logic                      busy,
   output logic                      err,
   output logic [1:0]                err_code,
   output logic                      overrun,
   output logic [1:0]                state_dbg
);

   localparam int IDX_W = $clog2(LINE_CHARS + MAX_DIGITS + 8);
   localparam int CNT_W = $clog2(MAX_DIGITS + 2);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] MAXD    = CNT_W'(MAX_DIGITS);
   localparam logic [VAL_W+3:0] TEN     = (VAL_W+4)'(10);
   localparam logic [VAL_W+3:0] LIM_U   = (VAL_W+4)'({VAL_W{1'b1}});
   localparam logic [VAL_W+3:0] LIM_POS = (VAL_W+4)'({(VAL_W-1){1'b1}});
   localparam logic [VAL_W+3:0] LIM_NEG = LIM_POS + (VAL_W+4)'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DIG = 2'd2} state_t;

   state_t                  state;
   logic [8*LINE_CHARS-1:0] line_q;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        cnt;
   logic [VAL_W-1:0]        acc;
   logic [CH_W-1:0]         ch_q;

   logic [31:0]             hdr4;
   logic [7:0]              c4, c5, cur;
   logic                    is_fire, is_set, hit, cur_digit, cur_term;
   logic [CH_W-1:0]         sel;
   logic [VAL_W+3:0]        prod, lim;
   logic [VAL_W-1:0]        commit;
`ifdef SIGNED_VAL_EN
   logic                    neg;
`endif

   // Positions past the end of the line read as NUL, which doubles as a terminator.
   function automatic logic [7:0] char_at(input logic [8*LINE_CHARS-1:0] l, input int k);
      if (k < 0 || k >= LINE_CHARS) return 8'h00;
      return l[8*(LINE_CHARS-k)-1 -: 8];
   endfunction

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_comb begin
      hdr4      = {char_at(line_q, 0), char_at(line_q, 1), char_at(line_q, 2), char_at(line_q, 3)};
      c4        = char_at(line_q, 4);
      c5        = char_at(line_q, 5);
      is_fire   = (hdr4 == "FIRE") && (c4 == 8'h20 || c4 == 8'h00);
      is_set    = (hdr4 == "SET ") && (c5 == 8'h20);
      hit       = 1'b0;
      sel       = '0;
      // Descending scan so the lowest matching channel is the one left selected.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (CH_LETTERS[8*i +: 8] == c4) begin
            hit = 1'b1;
            sel = CH_W'(i);
         end
      end
      cur       = char_at(line_q, int'(idx));
      cur_digit = (cur >= 8'h30) && (cur <= 8'h39);
      cur_term  = (cur == 8'h20) || (cur == 8'h00);
      prod      = ({4'b0000, acc} * TEN) + (VAL_W+4)'(cur[3:0]);
`ifdef SIGNED_VAL_EN
      lim       = neg ? LIM_NEG : LIM_POS;
      commit    = neg ? (~acc + VAL_W'(1)) : acc;
`else
      lim       = LIM_U;
      commit    = acc;
`endif
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         line_q   <= '0;
         idx      <= '0;
         cnt      <= '0;
         acc      <= '0;
         ch_q     <= '0;
`ifdef SIGNED_VAL_EN
         neg      <= 1'b0;
`endif
         values   <= RESET_VALS;
         update   <= '0;
         fire     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
         overrun  <= 1'b0;
      end else begin
         update  <= '0;
         fire    <= 1'b0;
         err     <= 1'b0;
         overrun <= line_ready && (state != IDLE);
         case (state)
            IDLE: begin
               if (line_ready) begin
                  line_q <= input_line;
                  state  <= HDR;
               end
            end
            HDR: begin
               state <= IDLE;
               if (is_fire) begin
                  fire <= 1'b1;
               end else if (is_set && hit) begin
                  ch_q  <= sel;
                  idx   <= IDX_W'(6);
                  cnt   <= '0;
                  acc   <= '0;
`ifdef SIGNED_VAL_EN
                  neg   <= 1'b0;
`endif
                  state <= DIG;
               end else begin
                  err      <= 1'b1;
                  err_code <= 2'd1;
               end
            end
            DIG: begin
               if (cur_digit && (cnt < MAXD)) begin
                  if (prod > lim) begin
                     err      <= 1'b1;
                     err_code <= 2'd3;
                     state    <= IDLE;
                  end else begin
                     acc <= prod[VAL_W-1:0];
                     cnt <= cnt + CNT_W'(1);
                     idx <= idx + IDX_W'(1);
                  end
               end
`ifdef SIGNED_VAL_EN
               else if ((cur == 8'h2D) && (idx == IDX_W'(6))) begin
                  neg <= 1'b1;
                  idx <= idx + IDX_W'(1);
               end
`endif
               else if (cur_term && (cnt != '0)) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (ch_q == CH_W'(i)) begin
                        values[VAL_W*i +: VAL_W] <= commit;
                        update[i]                <= 1'b1;
                     end
                  end
                  state <= IDLE;
               end else begin
                  err      <= 1'b1;
                  err_code <= 2'd2;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_cmd_interpreter.sv
// Bench for ps2_cmd_interpreter: default 32-bit instance plus an 8-bit/3-digit instance for overflow limits.
// Honours SIGNED_VAL_EN when defined for the bench build as well.
module tb_ps2_cmd_interpreter;
  localparam int LC = 32;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // Default instance
  logic [8*LC-1:0] input_line;
  logic            line_ready;
  logic [63:0]     values;
  logic [1:0]      update, err_code, state_dbg;
  logic            fire, busy, err, overrun;

  // Narrow instance
  logic [8*LC-1:0] input_line8;
  logic            line_ready8;
  logic [15:0]     values8;
  logic [1:0]      update8, err_code8, state_dbg8;
  logic            fire8, busy8, err8, overrun8;

  ps2_cmd_interpreter dut (
    .clock(clock), .resetn(resetn), .input_line(input_line), .line_ready(line_ready),
    .values(values), .update(update), .fire(fire), .busy(busy), .err(err),
    .err_code(err_code), .overrun(overrun), .state_dbg(state_dbg)
  );

  ps2_cmd_interpreter #(.VAL_W(8), .MAX_DIGITS(3), .RESET_VALS({8'd60, 8'd70})) dut8 (
    .clock(clock), .resetn(resetn), .input_line(input_line8), .line_ready(line_ready8),
    .values(values8), .update(update8), .fire(fire8), .busy(busy8), .err(err8),
    .err_code(err_code8), .overrun(overrun8), .state_dbg(state_dbg8)
  );

  int checks = 0;
  int errors = 0;

  // Event word: {kind, aux, values}; kind 1=update (aux=mask), 2=fire, 3=err (aux=code)
  logic [67:0] exp_q[$];
  logic [19:0] exp8_q[$];
  logic [31:0] m0, m1;
  logic [7:0]  m80, m81;

  logic [67:0] obs, expv;
  logic [19:0] obs8, expv8;
  int          nact, nact8;

  function automatic logic [8*LC-1:0] pack(input string s);
    logic [8*LC-1:0] l = '0;
    for (int k = 0; k < s.len() && k < LC; k++) l[8*(LC-k)-1 -: 8] = s[k];
    return l;
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock) begin
    if (resetn) begin
      nact = int'(update != 2'b00) + int'(fire) + int'(err);
      if (nact != 0) begin
        checks++;
        if (nact > 1) begin
          errors++;
          $display("FAIL strobe_exclusive: got %0d strobes required 1", nact);
        end
        if (update != 2'b00) obs = {2'd1, update, values};
        else if (fire)       obs = {2'd2, 2'd0, values};
        else                 obs = {2'd3, err_code, values};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h required none", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL event: got %h required %h", obs, expv);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      nact8 = int'(update8 != 2'b00) + int'(fire8) + int'(err8);
      if (nact8 != 0) begin
        checks++;
        if (update8 != 2'b00) obs8 = {2'd1, update8, values8};
        else if (fire8)       obs8 = {2'd2, 2'd0, values8};
        else                  obs8 = {2'd3, err_code8, values8};
        if (exp8_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event8: got %h required none", obs8);
        end else begin
          expv8 = exp8_q.pop_front();
          if (obs8 !== expv8) begin
            errors++;
            $display("FAIL event8: got %h required %h", obs8, expv8);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_upd(input int ch, input logic [31:0] v);
    if (ch == 0) m0 = v; else m1 = v;
    exp_q.push_back({2'd1, (ch == 0) ? 2'b01 : 2'b10, m1, m0});
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_q.push_back({2'd3, code, m1, m0});
  endtask

  task automatic push_fire();
    exp_q.push_back({2'd2, 2'd0, m1, m0});
  endtask

  task automatic push8_upd(input int ch, input logic [7:0] v);
    if (ch == 0) m80 = v; else m81 = v;
    exp8_q.push_back({2'd1, (ch == 0) ? 2'b01 : 2'b10, m81, m80});
  endtask

  task automatic push8_err(input logic [1:0] code);
    exp8_q.push_back({2'd3, code, m81, m80});
  endtask

  // Returns one tick after capture edge E0; the line is scrambled afterwards.
  task automatic send(input string s);
    @(posedge clock); #1;
    input_line = pack(s);
    line_ready = 1'b1;
    @(posedge clock); #1;
    line_ready = 1'b0;
    input_line = {8{$urandom()}};
  endtask

  task automatic send8(input string s);
    @(posedge clock); #1;
    input_line8 = pack(s);
    line_ready8 = 1'b1;
    @(posedge clock); #1;
    line_ready8 = 1'b0;
    input_line8 = {8{$urandom()}};
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || busy8) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (busy || busy8) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0b busy8=%0b required 0", busy, busy8);
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d/%0d required 0/0", exp_q.size(), exp8_q.size());
      exp_q.delete();
      exp8_q.delete();
    end
  endtask

  task automatic run_cmd(input string s);
    send(s);
    wait_idle(40);
  endtask

  task automatic run8(input string s);
    send8(s);
    wait_idle(40);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if (values !== {32'd60, 32'd70}) begin errors++; $display("FAIL reset_values: got %h required %h", values, {32'd60, 32'd70}); end
    checks++;
    if (values8 !== {8'd60, 8'd70}) begin errors++; $display("FAIL reset_values8: got %h required %h", values8, {8'd60, 8'd70}); end
    checks++;
    if ({busy, update, fire, err, err_code, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000", {busy, update, fire, err, err_code, overrun});
    end
    m0 = 32'd70; m1 = 32'd60; m80 = 8'd70; m81 = 8'd60;
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, update, fire, err, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL idle_quiet: got %b required 00000", {busy, update, fire, err, overrun});
    end
  endtask

  task automatic test_set_latency();
    push_upd(0, 32'd45);
    send("SET A 45");
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_e0: got %b required 1", busy); end
    for (int e = 1; e <= 3; e++) begin
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b1 || update !== 2'b00) begin
        errors++;
        $display("FAIL latency_e%0d: got busy=%b update=%b required busy=1 update=00", e, busy, update);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (update !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_e4: got update=%b busy=%b required update=01 busy=0", update, busy);
    end
    checks++;
    if (values !== {32'd60, 32'd45}) begin errors++; $display("FAIL value_a45: got %h required %h", values, {32'd60, 32'd45}); end
    @(posedge clock); #1;
    checks++;
    if (update !== 2'b00) begin errors++; $display("FAIL update_one_cycle: got %b required 00", update); end
    drain();
  endtask

  task automatic test_max_digits();
    int n = 0;
    push_upd(1, 32'd12345);
    send("SET V 12345");
    while (update === 2'b00 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n != 7 || update !== 2'b10) begin
      errors++;
      $display("FAIL five_digit_latency: got edge %0d update=%b required edge 7 update=10", n, update);
    end
    wait_idle(40);
    drain();
    push_err(2'd2);
    run_cmd("SET V 123456");
    drain();
    checks++;
    if (values[63:32] !== 32'd12345 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL six_digits: got ch1=%0d code=%0d required ch1=12345 code=2", values[63:32], err_code);
    end
  endtask

  task automatic test_commands();
    push_fire();
    send("FIRE");
    @(posedge clock); #1;
    checks++;
    if (fire !== 1'b1) begin errors++; $display("FAIL fire_e1: got %b required 1", fire); end
    @(posedge clock); #1;
    checks++;
    if (fire !== 1'b0) begin errors++; $display("FAIL fire_pulse: got %b required 0", fire); end
    wait_idle(40);
    push_fire();   run_cmd("FIRE X");
    push_err(2'd1); run_cmd("SET Q 5");
    push_err(2'd2); run_cmd("SET A ");
    push_err(2'd2); run_cmd("SET A 4x");
    push_err(2'd1); run_cmd("FIRE2");
    push_err(2'd1); run_cmd("set a 5");
    push_err(2'd1); run_cmd("SET A7");
    push_upd(0, 32'd7); run_cmd("SET A 007");
    drain();
    checks++;
    if (err_code !== 2'd1) begin errors++; $display("FAIL err_code_held: got %0d required 1", err_code); end
    push_upd(1, 32'd12); run_cmd("SET V 12 99");
`ifdef SIGNED_VAL_EN
    push_upd(0, 32'hFFFFFFF9); run_cmd("SET A -7");
    push_err(2'd2); run_cmd("SET A 7-");
`else
    push_err(2'd2); run_cmd("SET A -7");
`endif
    drain();
    checks++;
    if (values !== {m1, m0}) begin errors++; $display("FAIL values_after_cmds: got %h required %h", values, {m1, m0}); end
  endtask

  task automatic test_overflow8();
`ifdef SIGNED_VAL_EN
    push8_err(2'd3);    run8("SET A 128");
    push8_upd(0, 8'd127); run8("SET A 127");
    push8_upd(1, 8'h80);  run8("SET V -128");
    push8_err(2'd3);    run8("SET V -129");
`else
    push8_err(2'd3);    run8("SET A 256");
    push8_upd(0, 8'd255); run8("SET A 255");
`endif
    push8_err(2'd2);    run8("SET V 1000");
    push8_upd(1, 8'd99);  run8("SET V 099");
    drain();
    checks++;
    if (values8 !== {m81, m80}) begin errors++; $display("FAIL values8: got %h required %h", values8, {m81, m80}); end
    checks++;
    if (err_code8 !== 2'd2) begin errors++; $display("FAIL err_code8: got %0d required 2", err_code8); end
  endtask

  task automatic test_overrun();
    push_upd(0, 32'd321);
    send("SET A 321");
    input_line = pack("SET V 9");
    line_ready = 1'b1;
    @(posedge clock); #1;
    line_ready = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b required 1", overrun); end
    @(posedge clock); #1;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_one_cycle: got %b required 0", overrun); end
    wait_idle(40);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dropped_line_ran: got busy=%b required 0", busy); end
    drain();
    checks++;
    if (values !== {m1, 32'd321}) begin errors++; $display("FAIL overrun_values: got %h required %h", values, {m1, 32'd321}); end
  endtask

  task automatic test_back_to_back();
    int ch;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      ch = $urandom_range(0, 1);
      v  = 32'($urandom_range(0, 99999));
      push_upd(ch, v);
      run_cmd($sformatf("SET %s %0d", (ch == 1) ? "V" : "A", v));
    end
    drain();
    checks++;
    if (values !== {m1, m0}) begin errors++; $display("FAIL b2b_values: got %h required %h", values, {m1, m0}); end
  endtask

  task automatic test_reset_mid();
    send("SET A 98765");
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 2'd2) begin errors++; $display("FAIL in_dig: got state %0d required 2", state_dbg); end
    resetn = 1'b0;
    #1;
    m0 = 32'd70; m1 = 32'd60; m80 = 8'd70; m81 = 8'd60;
    checks++;
    if (values !== {32'd60, 32'd70} || busy !== 1'b0 || update !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got values=%h busy=%b update=%b required %h 0 00", values, busy, update, {32'd60, 32'd70});
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (values !== {32'd60, 32'd70} || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got values=%h busy=%b required %h 0", values, busy, {32'd60, 32'd70});
    end
    drain();
  endtask

  initial begin
    line_ready  = 1'b0;
    line_ready8 = 1'b0;
    input_line  = '0;
    input_line8 = '0;
    test_reset();
    test_set_latency();
    test_max_digits();
    test_commands();
    test_overflow8();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end
endmodule

// File: doc/ps2_cmd_interpreter.md
Name: ps2_cmd_interpreter

Overview:
- Parametrised successor to the keyboard-line command decoder.
- Accepts a completed ASCII line from the PS/2 line buffer and decodes "SET <letter> <digits>" commands into NUM_CH value registers, plus a "FIRE" command.
- Converts digits sequentially, one per clock, with length checks, overflow checks and error reporting.
- Feeds the velocity/angle/etc. inputs of the game physics block.

Parameters:
- LINE_CHARS, 32: line length in characters; line width is 8*LINE_CHARS.
- NUM_CH, 2: number of settable channels.
- VAL_W, 32: width of each channel value.
- MAX_DIGITS, 5: maximum digits accepted per value.
- CH_LETTERS, 16'h5641: packed 8*NUM_CH; channel i letter is CH_LETTERS[8*i+:8]. Default: ch0 'A', ch1 'V'.
- RESET_VALS, {32'd60,32'd70}: packed VAL_W*NUM_CH; channel i reset value is RESET_VALS[VAL_W*i+:VAL_W]. Default: ch0 = 70, ch1 = 60.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- input_line  in  8*LINE_CHARS  ASCII line; char k is at bits [8*(LINE_CHARS-k)-1 -: 8].
- line_ready  in  1  line valid; sampled only in IDLE.
- values  out  VAL_W*NUM_CH  channel registers (registered).
- update  out  NUM_CH  one-cycle strobe per channel when its value is written.
- fire  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle error strobe.
- err_code  out  2  1 = unknown command/letter, 2 = bad or empty digit field, 3 = overflow; held until the next err.
- overrun  out  1  one-cycle strobe when line_ready is high while busy.

Behaviour:
- Reset (async, resetn=0): values=RESET_VALS, update=0, fire=0, busy=0, err=0, err_code=0, overrun=0, state=IDLE, accumulator=0.
- IDLE: line_ready=1 at edge E0 → latch input_line into an internal line register, go to HDR. The input may change after E0.
- HDR (edge E1), checks against the latched line:
  - chars 0-3 = "FIRE" and char 4 is a terminator → fire=1 for the cycle after E1, return to IDLE.
  - chars 0-3 = "SET " and char 5 = ' ' → search CH_LETTERS for char 4.
    - Match on channel i → record i, set digit index to 6, clear accumulator, go to DIG.
    - If several channels share a letter, the lowest index wins.
  - Anything else → err, err_code=1, return to IDLE.
- Terminator: 0x20, 0x00, or index >= LINE_CHARS.
- DIG: one char per edge.
  - '0'-'9' with digit count < MAX_DIGITS → acc <= acc*10 + (c-8'h30), index+1.
    - Compute the product at VAL_W+4 bits.
    - If the result exceeds 2^VAL_W-1 → err, code 3, no write, return to IDLE.
  - Terminator with digit count >= 1 → values[i] <= acc, update[i]=1 next cycle, return to IDLE.
  - Terminator with 0 digits, a non-digit, or an (MAX_DIGITS+1)th digit → err, code 2, no write, return to IDLE.
- Latency for D digits: capture at E0, header at E1, digits at E2..E(D+1), write at E(D+2). update is high in the cycle following E(D+2), and busy falls at the same edge.
- Leading zeros are allowed and count toward MAX_DIGITS. Characters after the terminator are ignored.
- line_ready while busy: the line is ignored and overrun pulses. A line_ready held high in IDLE for multiple cycles re-triggers only after the block returns to IDLE; the bench must pulse it.
- Reset asserted mid-conversion: the block aborts with no partial write and values return to RESET_VALS.
- Only one of update/fire/err is asserted in any cycle. overrun may coincide with any of them.

Optional Feature:
- Macro SIGNED_VAL_EN.
- Defined:
  - '-' is accepted at char 6 only and does not count as a digit.
  - The committed value is two's-complement negated.
  - Magnitude limit is 2^(VAL_W-1) for negative values and 2^(VAL_W-1)-1 for positive values; above that → code 3.
- Undefined: '-' → err code 2. Values are unsigned.

Test Plan:
- Reset, no stimulus → values ch0=70, ch1=60, busy=0, no strobes.
- "SET A 45" + pulse → after 4 edges (E0..E3 plus write edge E4) ch0=45, update=2'b01 for one cycle, ch1 unchanged.
- "SET V 12345" → ch1=12345, update=2'b10 at E7. Then "SET V 123456" → err, code 2, ch1 stays 12345.
- "FIRE" → fire one cycle after E1. "SET Q 5" → err code 1. "SET A " (empty digit field) → err code 2.
- VAL_W=8, MAX_DIGITS=3: "SET A 256" → err code 3, ch0 unchanged. "SET A 255" → ch0=255.
- line_ready pulsed during a busy conversion → overrun=1, first command completes, second is dropped. resetn low mid-DIG → values=RESET_VALS, no update.
- With SIGNED_VAL_EN: "SET A -7" → ch0=32'hFFFFFFF9.
